// File: rtl/mem_arb.sv
// mem_arb: two-port (instruction/data) arbiter onto a single downstream memory
// port, with an in-order tracking FIFO that routes responses back to their source.
module mem_arb #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    // instruction port
    input  logic             core__i_ren,
    input  logic [31:0]      core__i_addr,
    output logic             i__core_accept,
    output logic             i__core_val,
    output logic             i__core_error,
    output logic [31:0]      i__core_rdata,
    output logic [31:0]      i__core_pc,
    // data port
    input  logic             core__d_ren,
    input  logic [3:0]       core__d_wen,
    input  logic [31:0]      core__d_addr,
    input  logic [31:0]      core__d_wdata,
    input  logic [TAG_W-1:0] core__d_req_tag,
    output logic             d__core_accept,
    output logic             d__core_val,
    output logic             d__core_error,
    output logic [31:0]      d__core_rdata,
    output logic [TAG_W-1:0] d__core_resp_tag,
    // downstream port
    output logic             mem_req,
    output logic [3:0]       mem_wen,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_accept,
    input  logic             mem_val,
    input  logic             mem_error,
    input  logic [31:0]      mem_rdata,
    // diagnostics
    output logic             err_unexp
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic {SRC_I = 1'b0, SRC_D = 1'b1} src_e;

    typedef struct packed {
        src_e             src;
        logic [TAG_W-1:0] tag;
        logic [31:0]      addr;
    } entry_t;

    logic           i_req;
    logic           d_req;
    logic           grant_d;
    logic           xfer;
    logic           pop;
    logic           empty;
    src_e           last_grant;
    logic [PTR_W:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    entry_t         fifo [DEPTH];
    entry_t         head;

    // Arbitration, downstream muxing and FIFO handshake decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        i_req          = core__i_ren;
        d_req          = core__d_ren | (|core__d_wen);
        empty          = (count == '0);
        mem_req        = (i_req | d_req) && (count != FULL_CNT);
        grant_d        = d_req && (!i_req || (last_grant == SRC_I));
        mem_addr       = grant_d ? core__d_addr  : core__i_addr;
        mem_wdata      = grant_d ? core__d_wdata : 32'h0;
        mem_wen        = grant_d ? core__d_wen   : 4'h0;
        xfer           = mem_req && mem_accept;
        i__core_accept = xfer && !grant_d;
        d__core_accept = xfer && grant_d;
        pop            = mem_val && !empty;
        head           = fifo[rd_ptr];
    end

    // Outstanding count, FIFO pointers, round-robin history and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_grant <= SRC_I;
            err_unexp  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (xfer) begin
                wr_ptr     <= wr_ptr + 1'b1;
                last_grant <= grant_d ? SRC_D : SRC_I;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({xfer, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (mem_val && empty) err_unexp <= 1'b1;
        end
    end

    // Tracking FIFO storage written on each completed transfer.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; entries are only read behind a valid count.
        if (xfer) begin
            fifo[wr_ptr] <= '{src:  grant_d ? SRC_D : SRC_I,
                               tag:  core__d_req_tag,
                               addr: grant_d ? core__d_addr : core__i_addr};
        end
    end

    // Registered response routing; payload registers hold between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i__core_val      <= 1'b0;
            i__core_error    <= 1'b0;
            i__core_rdata    <= '0;
            i__core_pc       <= '0;
            d__core_val      <= 1'b0;
            d__core_error    <= 1'b0;
            d__core_rdata    <= '0;
            d__core_resp_tag <= '0;
        end else begin
            i__core_val <= pop && (head.src == SRC_I);
            d__core_val <= pop && (head.src == SRC_D);
            if (pop && head.src == SRC_I) begin
                i__core_rdata <= mem_rdata;
                i__core_error <= mem_error;
                i__core_pc    <= head.addr;
            end
            if (pop && head.src == SRC_D) begin
                d__core_rdata    <= mem_rdata;
                d__core_error    <= mem_error;
                d__core_resp_tag <= head.tag;
            end
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: table-driven, directed and randomized checks of mem_arb against
// a queue-based reference model.
module tb_mem_arb;

    localparam int DEPTH = 4;
    localparam int TAG_W = 11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             core__i_ren = 1'b0;
    logic [31:0]      core__i_addr = '0;
    logic             i__core_accept, i__core_val, i__core_error;
    logic [31:0]      i__core_rdata, i__core_pc;
    logic             core__d_ren = 1'b0;
    logic [3:0]       core__d_wen = '0;
    logic [31:0]      core__d_addr = '0;
    logic [31:0]      core__d_wdata = '0;
    logic [TAG_W-1:0] core__d_req_tag = '0;
    logic             d__core_accept, d__core_val, d__core_error;
    logic [31:0]      d__core_rdata;
    logic [TAG_W-1:0] d__core_resp_tag;
    logic             mem_req;
    logic [3:0]       mem_wen;
    logic [31:0]      mem_addr, mem_wdata;
    logic             mem_accept = 1'b0;
    logic             mem_val = 1'b0;
    logic             mem_error = 1'b0;
    logic [31:0]      mem_rdata = '0;
    logic             err_unexp;

    always #5 clk = ~clk;

    mem_arb #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .core__i_ren(core__i_ren), .core__i_addr(core__i_addr),
        .i__core_accept(i__core_accept), .i__core_val(i__core_val),
        .i__core_error(i__core_error), .i__core_rdata(i__core_rdata),
        .i__core_pc(i__core_pc),
        .core__d_ren(core__d_ren), .core__d_wen(core__d_wen),
        .core__d_addr(core__d_addr), .core__d_wdata(core__d_wdata),
        .core__d_req_tag(core__d_req_tag),
        .d__core_accept(d__core_accept), .d__core_val(d__core_val),
        .d__core_error(d__core_error), .d__core_rdata(d__core_rdata),
        .d__core_resp_tag(d__core_resp_tag),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_accept(mem_accept), .mem_val(mem_val),
        .mem_error(mem_error), .mem_rdata(mem_rdata),
        .err_unexp(err_unexp)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit               is_d;
        logic [TAG_W-1:0] tag;
        logic [31:0]      addr;
    } ent_t;

    ent_t             q[$];
    bit               m_last_d, m_err;
    bit               m_ival, m_dval, m_ierr, m_derr;
    logic [31:0]      m_irdata, m_pc, m_drdata;
    logic [TAG_W-1:0] m_tag;

    // current cycle inputs and model decisions
    logic             c_ir, c_dr, c_ma, c_mv, c_me;
    logic [3:0]       c_dw;
    logic [31:0]      c_ia, c_da, c_mr;
    logic [TAG_W-1:0] c_dt;
    bit               e_gd, e_x;

    task automatic model_clear();
        q.delete();
        m_last_d = 0; m_err = 0;
        m_ival = 0; m_dval = 0; m_ierr = 0; m_derr = 0;
        m_irdata = '0; m_pc = '0; m_drdata = '0; m_tag = '0;
    endtask

    task automatic check_regs();
        check("i_val", i__core_val, m_ival);
        check("d_val", d__core_val, m_dval);
        check("err_unexp", err_unexp, m_err);
        check("i_rdata", i__core_rdata, m_irdata);
        check("i_error", i__core_error, m_ierr);
        check("i_pc", i__core_pc, m_pc);
        check("d_rdata", d__core_rdata, m_drdata);
        check("d_error", d__core_error, m_derr);
        check("d_tag", d__core_resp_tag, m_tag);
    endtask

    // Apply one cycle's inputs and check the combinational side.
    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dwd,
                         input logic [TAG_W-1:0] dt, input logic ma, input logic mv,
                         input logic me, input logic [31:0] mr);
        bit i_r, d_r, e_req;
        core__i_ren = ir; core__i_addr = ia;
        core__d_ren = dr; core__d_wen = dw; core__d_addr = da;
        core__d_wdata = dwd; core__d_req_tag = dt;
        mem_accept = ma; mem_val = mv; mem_error = me; mem_rdata = mr;
        c_ir = ir; c_ia = ia; c_dr = dr; c_dw = dw; c_da = da; c_dt = dt;
        c_ma = ma; c_mv = mv; c_me = me; c_mr = mr;
        #1;
        i_r   = ir;
        d_r   = dr || (dw != 4'h0);
        e_req = (i_r || d_r) && (q.size() < DEPTH);
        e_gd  = d_r && (!i_r || !m_last_d);
        e_x   = e_req && ma;
        check("mem_req", mem_req, e_req);
        check("i_accept", i__core_accept, e_x && !e_gd);
        check("d_accept", d__core_accept, e_x && e_gd);
        if (e_req) begin
            check("mem_addr", mem_addr, e_gd ? da : ia);
            check("mem_wen", mem_wen, e_gd ? dw : 4'h0);
            if (e_gd) check("mem_wdata", mem_wdata, dwd);
        end
    endtask

    // Update the model with the cycle's events, clock, check registered side.
    task automatic advance();
        ent_t h;
        m_ival = 0; m_dval = 0;
        if (c_mv) begin
            if (q.size() == 0) m_err = 1;
            else begin
                h = q.pop_front();
                if (h.is_d) begin
                    m_dval = 1; m_drdata = c_mr; m_derr = c_me; m_tag = h.tag;
                end else begin
                    m_ival = 1; m_irdata = c_mr; m_ierr = c_me; m_pc = h.addr;
                end
            end
        end
        if (e_x) begin
            q.push_back('{is_d: e_gd, tag: c_dt, addr: e_gd ? c_da : c_ia});
            m_last_d = e_gd;
        end
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dwd,
                         input logic [TAG_W-1:0] dt, input logic ma, input logic mv,
                         input logic me, input logic [31:0] mr);
        drive(ir, ia, dr, dw, da, dwd, dt, ma, mv, me, mr);
        advance();
    endtask

    task automatic idle(input logic mv, input logic [31:0] mr);
        cycle(0, 0, 0, 4'h0, 0, 0, '0, 0, mv, 0, mr);
    endtask

    task automatic do_reset();
        core__i_ren = 0; core__d_ren = 0; core__d_wen = '0;
        mem_accept = 0; mem_val = 0; mem_error = 0;
        rst = 1'b1;
        #2;
        model_clear();
        check_regs();
        check("rst_mem_req", mem_req, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic [31:0] da;
        logic        ma;
        logic        mv;
        logic [31:0] mr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iacc;
        logic        e_dacc;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            ir  ia         dr  da         ma  mv  mr            req addr       ia dacc
        tbl[0]  = '{1, 32'h100, 1, 32'h200, 1, 0, 32'h0,        1, 32'h200, 0, 1}; // first tie -> D
        tbl[1]  = '{1, 32'h100, 1, 32'h200, 1, 0, 32'h0,        1, 32'h100, 1, 0}; // then I
        tbl[2]  = '{1, 32'h100, 1, 32'h200, 0, 0, 32'h0,        1, 32'h200, 0, 0}; // stalled grant
        tbl[3]  = '{1, 32'h100, 1, 32'h200, 1, 0, 32'h0,        1, 32'h200, 0, 1}; // same grant retried
        tbl[4]  = '{1, 32'h104, 0, 32'h0,   1, 0, 32'h0,        1, 32'h104, 1, 0}; // fills to DEPTH
        tbl[5]  = '{1, 32'h108, 1, 32'h208, 1, 0, 32'h0,        0, 32'h0,   0, 0}; // full
        tbl[6]  = '{1, 32'h108, 1, 32'h208, 1, 1, 32'hAAAA0001, 0, 32'h0,   0, 0}; // full despite pop
        tbl[7]  = '{1, 32'h108, 1, 32'h208, 1, 0, 32'h0,        1, 32'h208, 0, 1}; // re-granted
        tbl[8]  = '{0, 32'h0,   0, 32'h0,   0, 1, 32'hAAAA0002, 0, 32'h0,   0, 0};
        tbl[9]  = '{0, 32'h0,   0, 32'h0,   0, 1, 32'hAAAA0003, 0, 32'h0,   0, 0};
        tbl[10] = '{0, 32'h0,   0, 32'h0,   0, 1, 32'hAAAA0004, 0, 32'h0,   0, 0};
        tbl[11] = '{0, 32'h0,   0, 32'h0,   0, 1, 32'hAAAA0005, 0, 32'h0,   0, 0};

        do_reset();

        // Table: arbitration, stall, full and drain from reset.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].ir, tbl[i].ia, tbl[i].dr, 4'h0, tbl[i].da, 32'h0, 11'(i),
                  tbl[i].ma, tbl[i].mv, 1'b0, tbl[i].mr);
            check($sformatf("tbl%0d_req", i), mem_req, tbl[i].e_req);
            check($sformatf("tbl%0d_iacc", i), i__core_accept, tbl[i].e_iacc);
            check($sformatf("tbl%0d_dacc", i), d__core_accept, tbl[i].e_dacc);
            if (tbl[i].e_req) check($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
            advance();
        end

        // D write with tag 0x155, then its response.
        do_reset();
        cycle(0, 0, 0, 4'hF, 32'h40, 32'hDEADBEEF, 11'h155, 1, 0, 0, 0);
        idle(1, 32'h0);
        check("wr_d_val", d__core_val, 1'b1);
        check("wr_tag", d__core_resp_tag, 11'h155);
        check("wr_i_val", i__core_val, 1'b0);
        idle(0, 0);
        check("wr_d_val_drop", d__core_val, 1'b0);
        check("wr_tag_hold", d__core_resp_tag, 11'h155);

        // Four fetches fill the tracker; the fifth waits for the first response.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 32'(i * 4), 0, 4'h0, 0, 0, '0, 1, 0, 0, 0);
        drive(1, 32'h10, 0, 4'h0, 0, 0, '0, 1, 0, 0, 0);
        check("full_req", mem_req, 1'b0);
        advance();
        drive(1, 32'h10, 0, 4'h0, 0, 0, '0, 1, 1, 0, 32'h1234);
        check("full_pop_req", mem_req, 1'b0);
        advance();
        drive(1, 32'h10, 0, 4'h0, 0, 0, '0, 1, 0, 0, 0);
        check("regrant_acc", i__core_accept, 1'b1);
        advance();
        check("full_first_pc", i__core_pc, 32'h0);
        for (int i = 0; i < 4; i++) idle(1, 32'(100 + i));
        check("full_last_pc", i__core_pc, 32'h10);

        // Interleaved I/D responses come back in request order.
        do_reset();
        cycle(1, 32'h10, 0, 4'h0, 0, 0, '0, 1, 0, 0, 0);
        cycle(0, 0, 1, 4'h0, 32'h20, 0, 11'd7, 1, 0, 0, 0);
        cycle(1, 32'h14, 0, 4'h0, 0, 0, '0, 1, 0, 0, 0);
        idle(1, 32'h111);
        check("ord1_ival", i__core_val, 1'b1);
        check("ord1_pc", i__core_pc, 32'h10);
        idle(1, 32'h222);
        check("ord2_dval", d__core_val, 1'b1);
        check("ord2_tag", d__core_resp_tag, 11'd7);
        idle(1, 32'h333);
        check("ord3_ival", i__core_val, 1'b1);
        check("ord3_pc", i__core_pc, 32'h14);

        // Unexpected response sets a sticky flag.
        do_reset();
        idle(1, 32'h55);
        check("unexp_set", err_unexp, 1'b1);
        check("unexp_noval", i__core_val | d__core_val, 1'b0);
        idle(0, 0);
        idle(0, 0);
        check("unexp_sticky", err_unexp, 1'b1);

        // Reset with three entries outstanding discards them.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 32'h80 + 32'(i * 4), 0, 4'h0, 0, 0, '0, 1, 0, 0, 0);
        do_reset();
        check("rst_err_clear", err_unexp, 1'b0);
        idle(1, 32'h66);
        check("rst_late_unexp", err_unexp, 1'b1);
        check("rst_late_noval", i__core_val | d__core_val, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1, 32'(i), 0, 4'h0, 0, 0, '0, 1, 0, 0, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            logic [3:0] dw;
            dw = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            cycle(1'($urandom), $urandom, 1'($urandom), dw, $urandom, $urandom,
                  11'($urandom), $urandom_range(0, 3) != 0,
                  (q.size() > 0) && ($urandom_range(0, 1) == 1),
                  1'($urandom), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
